// File: rtl/syn_m_pkg.sv
// syn_m_pkg: shared types and constants for the GPS-disciplined frame scheduler.
package syn_m_pkg;

  // Width of every microsecond quantity (counter, period, info delay).
  localparam int US_W = 20;

  // Default GPS window half-width and holdover length.
  localparam int TOL_US_DEF   = 50;
  localparam int HOLD_MAX_DEF = 10;

  // Saturation value of the microsecond counter.
  localparam logic [US_W-1:0] US_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_HOLD = 2'd2
  } sched_state_t;

endpackage

// File: rtl/syn_m_pps_sync.sv
// syn_m_pps_sync: brings the asynchronous GPS PPS into clk_sys with a
// two-flop synchronizer, then produces a registered one-cycle rising-edge pulse.
module syn_m_pps_sync (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic gps_pluse,
  output logic gps_rise
);

  logic meta_reg;
  logic sync_reg;
  logic edge_reg;
  logic rise_reg;

  // Synchronizer chain plus edge register; rise is registered to give a clean strobe.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
      edge_reg <= 1'b0;
      rise_reg <= 1'b0;
    end else begin
      meta_reg <= gps_pluse;
      sync_reg <= meta_reg;
      edge_reg <= sync_reg;
      rise_reg <= sync_reg & ~edge_reg;
    end
  end

  assign gps_rise = rise_reg;

endmodule

// File: rtl/syn_m_sched.sv
// syn_m_sched: GPS-disciplined scheduler issuing fire_sync each period and
// fire_info a configurable delay later, with busy-aware info arbitration.
// Holdover free-run after GPS loss exists only when SYN_M_HOLDOVER_EN is defined;
// otherwise a LOCK timeout drops straight back to IDLE.
module syn_m_sched
  import syn_m_pkg::*;
#(
  parameter int TOL_US   = TOL_US_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF
) (
  input  logic            clk_sys,
  input  logic            rst_n,
  input  logic            pluse_us,
  input  logic            gps_pluse,
  input  logic [US_W-1:0] cfg_period_us,
  input  logic [US_W-1:0] cfg_info_dly_us,
  input  logic            sync_busy,
  input  logic            info_busy,
  output logic            fire_sync,
  output logic            fire_info,
  output logic            gps_lock,
  output logic            holdover,
  output logic [US_W-1:0] us_cnt
);

  localparam int USX_W = US_W + 1;
  localparam int HC_W  = $clog2(HOLD_MAX + 2);
  localparam logic [USX_W-1:0] TOL_X    = USX_W'(TOL_US);
  localparam logic [HC_W-1:0]  HOLD_LIM = HC_W'(HOLD_MAX);

  sched_state_t    state_reg;
  logic [US_W-1:0] us_cnt_reg;
  logic [HC_W-1:0] hold_cnt_reg;
  logic            fire_sync_reg;
  logic            fire_info_reg;
  logic            gps_lock_reg;
  logic            holdover_reg;
  logic            armed_reg;
  logic            seen_reg;
  logic            pending_reg;

  logic             gps_rise;
  logic [USX_W-1:0] cnt_x;
  logic [USX_W-1:0] inc_x;
  logic [USX_W-1:0] period_x;
  logic [USX_W-1:0] win_lo;
  logic [USX_W-1:0] win_hi;
  logic             in_window;
  logic             lock_timeout;
  logic             hold_period;
  logic             hold_done;
  logic             sync_req;
  logic             to_idle;
  logic             info_hit;
  logic             info_want;

  // Overlapping frames are the transmitters' problem, so info_busy never gates a strobe.
  logic unused_info_busy;
  assign unused_info_busy = info_busy;

  syn_m_pps_sync u_pps_sync (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .gps_pluse (gps_pluse),
    .gps_rise  (gps_rise)
  );

  // One extra bit keeps period+TOL and the counter increment free of wrap-around.
  assign cnt_x        = {1'b0, us_cnt_reg};
  assign inc_x        = cnt_x + 1'b1;
  assign period_x     = {1'b0, cfg_period_us};
  assign win_hi       = period_x + TOL_X;
  assign win_lo       = (period_x > TOL_X) ? (period_x - TOL_X) : '0;
  assign in_window    = (cnt_x >= win_lo) && (cnt_x <= win_hi);
  assign lock_timeout = pluse_us && (inc_x >= win_hi);
  assign hold_period  = pluse_us && (inc_x >= period_x);
  assign hold_done    = (hold_cnt_reg >= HOLD_LIM);

  // Info becomes due once per period, only while a period is running and the delay fits in it.
  assign info_hit  = armed_reg && !seen_reg && (us_cnt_reg == cfg_info_dly_us) &&
                     (cfg_info_dly_us < cfg_period_us);
  assign info_want = pending_reg || info_hit;

  // Decode this cycle's scheduling events: a sync request, or an exit to IDLE.
  always_comb begin
    sync_req = 1'b0;
    to_idle  = 1'b0;
    case (state_reg)
      ST_IDLE: sync_req = gps_rise;
      ST_LOCK: begin
        if (gps_rise && in_window) begin
          sync_req = 1'b1;
        end else if (lock_timeout) begin
`ifdef SYN_M_HOLDOVER_EN
          sync_req = 1'b1;
`else
          to_idle = 1'b1;
`endif
        end
      end
      ST_HOLD: begin
        if (gps_rise) begin
          sync_req = 1'b1;
        end else if (hold_period) begin
          if (hold_done) to_idle = 1'b1;
          else           sync_req = 1'b1;
        end
      end
      default: to_idle = 1'b1;
    endcase
  end

  // Lock state machine with registered lock/holdover flags and the holdover fire counter.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      hold_cnt_reg <= '0;
      gps_lock_reg <= 1'b0;
      holdover_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (sync_req) begin
            state_reg    <= ST_LOCK;
            gps_lock_reg <= 1'b1;
          end
        end
        ST_LOCK: begin
          if (lock_timeout && !(gps_rise && in_window)) begin
`ifdef SYN_M_HOLDOVER_EN
            // The timeout fire itself is the first holdover period.
            state_reg    <= ST_HOLD;
            hold_cnt_reg <= HC_W'(1);
            gps_lock_reg <= 1'b0;
            holdover_reg <= 1'b1;
`else
            state_reg    <= ST_IDLE;
            gps_lock_reg <= 1'b0;
`endif
          end
        end
        ST_HOLD: begin
          if (gps_rise) begin
            state_reg    <= ST_LOCK;
            hold_cnt_reg <= '0;
            gps_lock_reg <= 1'b1;
            holdover_reg <= 1'b0;
          end else if (to_idle) begin
            state_reg    <= ST_IDLE;
            hold_cnt_reg <= '0;
            holdover_reg <= 1'b0;
          end else if (sync_req) begin
            hold_cnt_reg <= hold_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          hold_cnt_reg <= '0;
          gps_lock_reg <= 1'b0;
          holdover_reg <= 1'b0;
        end
      endcase
    end
  end

  // Microsecond counter and sync strobe: the counter restarts at zero with every fire_sync.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      us_cnt_reg    <= '0;
      fire_sync_reg <= 1'b0;
    end else begin
      fire_sync_reg <= sync_req;
      if (sync_req) begin
        us_cnt_reg <= '0;
      end else if (pluse_us && (us_cnt_reg != US_MAX)) begin
        us_cnt_reg <= us_cnt_reg + 1'b1;
      end
    end
  end

  // Info arbitration: sync wins, busy defers, a new period or loss of lock drops it.
  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      armed_reg     <= 1'b0;
      seen_reg      <= 1'b0;
      pending_reg   <= 1'b0;
      fire_info_reg <= 1'b0;
    end else if (sync_req) begin
      armed_reg     <= 1'b1;
      seen_reg      <= 1'b0;
      pending_reg   <= 1'b0;
      fire_info_reg <= 1'b0;
    end else if (to_idle) begin
      armed_reg     <= 1'b0;
      pending_reg   <= 1'b0;
      fire_info_reg <= 1'b0;
    end else begin
      if (info_hit) seen_reg <= 1'b1;
      pending_reg   <= info_want && sync_busy;
      fire_info_reg <= info_want && !sync_busy;
    end
  end

  assign fire_sync = fire_sync_reg;
  assign fire_info = fire_info_reg;
  assign gps_lock  = gps_lock_reg;
  assign holdover  = holdover_reg;
  assign us_cnt    = us_cnt_reg;

endmodule
